// File: rtl/bus_arbiter_rr.sv
// ---------------------------------------------------------------------------
// bus_arbiter_rr
//   Round-robin arbiter that hands ownership of the shared system bus to one
//   of four masters. The owner keeps the bus until it releases its request;
//   all grant changes are registered so ownership never changes mid-cycle.
//
//   Optional feature macro: BUS_ARB_TIMEOUT_EN
//     When defined, a watchdog force-releases an owner that sees m_rdy_ high
//     for TIMEOUT_CYCLES consecutive owned cycles. The released master is
//     then blocked until its request has been seen high once.
//
// Ports:
//   clk                 system clock
//   reset               synchronous, active-high reset
//   m0_req_..m3_req_    master bus requests, active low
//   m_rdy_              slave ready, active low (watchdog only)
//   m0_grnt_..m3_grnt_  master grants, active low, registered
//   owner               index of current/last owner, registered
//   bus_busy            high while any grant is asserted, registered
//   timeout             one-cycle pulse on a forced release, registered
// ---------------------------------------------------------------------------
module bus_arbiter_rr #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_CNT_W       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       m0_req_,
  input  logic       m1_req_,
  input  logic       m2_req_,
  input  logic       m3_req_,
  input  logic       m_rdy_,
  output logic       m0_grnt_,
  output logic       m1_grnt_,
  output logic       m2_grnt_,
  output logic       m3_grnt_,
  output logic [1:0] owner,
  output logic       bus_busy,
  output logic       timeout
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  localparam logic [TO_CNT_W-1:0] TO_LIMIT = TO_CNT_W'(TIMEOUT_CYCLES);

  state_t      state_r, state_nxt_s;
  logic [1:0]  last_r, last_nxt_s;
  logic [1:0]  owner_r, owner_nxt_s;
  logic [3:0]  grnt_r, grnt_nxt_s;      // active low, bit i = master i
  logic        busy_r, busy_nxt_s;
  logic        timeout_r, timeout_nxt_s;

  logic [3:0]  req_s;                   // active-high view of the requests
  logic [3:0]  block_s;                 // masters excluded from arbitration
  logic        force_s;                 // watchdog expired for current owner
  logic        forced_rel_s;            // owner still requesting but released
  logic [2:0]  pick_s;                  // {found, index}

  assign req_s = ~{m3_req_, m2_req_, m1_req_, m0_req_};

  // First candidate scanning last+1, last+2, last+3, last; returns {found, idx}.
  function automatic logic [2:0] rr_pick(input logic [3:0] cand,
                                         input logic [1:0] last);
    logic [1:0] idx;
    rr_pick = 3'b000;
    // Walk from the farthest offset down so the nearest candidate wins.
    for (int i = 4; i >= 1; i--) begin
      idx = last + 2'(i);
      if (cand[idx]) begin
        rr_pick = {1'b1, idx};
      end else begin
        rr_pick = rr_pick;
      end
    end
  endfunction

`ifdef BUS_ARB_TIMEOUT_EN
  logic [TO_CNT_W-1:0] to_cnt_r;
  logic [3:0]          block_r, block_nxt_s;

  assign force_s = (state_r == OWNED) && (to_cnt_r == TO_LIMIT);
  assign block_s = block_r;

  // Watchdog counter: cleared on grant change or ready, saturating otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt_r <= {TO_CNT_W{1'b0}};
    end else if ((grnt_nxt_s != grnt_r) || !m_rdy_) begin
      to_cnt_r <= {TO_CNT_W{1'b0}};
    end else if ((state_r == OWNED) && (to_cnt_r != {TO_CNT_W{1'b1}})) begin
      to_cnt_r <= to_cnt_r + {{(TO_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      to_cnt_r <= to_cnt_r;
    end
  end

  // A block clears once the master's request is seen high; a forced release sets it.
  always_comb begin
    block_nxt_s = block_r & req_s;
    if (forced_rel_s) begin
      block_nxt_s = block_nxt_s | (4'b0001 << owner_r);
    end else begin
      block_nxt_s = block_nxt_s;
    end
  end

  // Block flag register.
  always_ff @(posedge clk) begin
    if (reset) begin
      block_r <= 4'b0000;
    end else begin
      block_r <= block_nxt_s;
    end
  end
`else
  logic unused_s;

  // m_rdy_ and the watchdog limit have no function without the watchdog.
  assign unused_s = ^{m_rdy_, TO_LIMIT};
  assign force_s  = 1'b0;
  assign block_s  = 4'b0000;
`endif

  // Only a release while the owner still requests counts as forced.
  assign forced_rel_s = force_s && req_s[owner_r];

  // Next-state and arbitration logic.
  always_comb begin
    state_nxt_s   = state_r;
    last_nxt_s    = last_r;
    owner_nxt_s   = owner_r;
    grnt_nxt_s    = grnt_r;
    busy_nxt_s    = busy_r;
    timeout_nxt_s = 1'b0;
    pick_s        = 3'b000;
    case (state_r)
      IDLE: begin
        pick_s = rr_pick(req_s & ~block_s, last_r);
        if (pick_s[2]) begin
          state_nxt_s = OWNED;
          owner_nxt_s = pick_s[1:0];
          grnt_nxt_s  = ~(4'b0001 << pick_s[1:0]);
          busy_nxt_s  = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      OWNED: begin
        if (!req_s[owner_r] || force_s) begin
          last_nxt_s    = owner_r;
          timeout_nxt_s = forced_rel_s;
          // The outgoing owner never wins the same-edge handover.
          pick_s = rr_pick(req_s & ~block_s & ~(4'b0001 << owner_r), owner_r);
          if (pick_s[2]) begin
            owner_nxt_s = pick_s[1:0];
            grnt_nxt_s  = ~(4'b0001 << pick_s[1:0]);
          end else begin
            state_nxt_s = IDLE;
            grnt_nxt_s  = 4'b1111;
            busy_nxt_s  = 1'b0;
          end
        end else begin
          state_nxt_s = OWNED;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        grnt_nxt_s  = 4'b1111;
        busy_nxt_s  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset drops any grant immediately.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      last_r    <= 2'd3;
      owner_r   <= 2'd0;
      grnt_r    <= 4'b1111;
      busy_r    <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      last_r    <= last_nxt_s;
      owner_r   <= owner_nxt_s;
      grnt_r    <= grnt_nxt_s;
      busy_r    <= busy_nxt_s;
      timeout_r <= timeout_nxt_s;
    end
  end

  assign m0_grnt_ = grnt_r[0];
  assign m1_grnt_ = grnt_r[1];
  assign m2_grnt_ = grnt_r[2];
  assign m3_grnt_ = grnt_r[3];
  assign owner    = owner_r;
  assign bus_busy = busy_r;
  assign timeout  = timeout_r;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter_rr
//   Directed bench for bus_arbiter_rr. Observed outputs are packed as
//   {m3..m0 grnt_, owner, bus_busy, timeout} and compared against
//   hand-computed values one clock after each stimulus change.
// ---------------------------------------------------------------------------
module tb_bus_arbiter_rr;

  logic       clk;
  logic       reset;
  logic [3:0] req_v;      // active low, bit i = master i
  logic       m_rdy_;
  logic       m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_;
  logic [1:0] owner;
  logic       bus_busy;
  logic       timeout;

  logic [3:0] grnt_s;
  logic [7:0] obs_s;

  int tests_run;
  int tests_failed;

  assign grnt_s = {m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_};
  assign obs_s  = {grnt_s, owner, bus_busy, timeout};

  bus_arbiter_rr #(
    .TIMEOUT_CYCLES(4),
    .TO_CNT_W      (8)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .m0_req_ (req_v[0]),
    .m1_req_ (req_v[1]),
    .m2_req_ (req_v[2]),
    .m3_req_ (req_v[3]),
    .m_rdy_  (m_rdy_),
    .m0_grnt_(m0_grnt_),
    .m1_grnt_(m1_grnt_),
    .m2_grnt_(m2_grnt_),
    .m3_grnt_(m3_grnt_),
    .owner   (owner),
    .bus_busy(bus_busy),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge, then sample 1 ns later; every cycle checks grant exclusivity.
  task automatic tick();
    @(posedge clk);
    #1;
    tests_run++;
    if ($countones(~grnt_s) > 1) begin
      tests_failed++;
      $display("FAIL onehot_grant: grnt_=%b, required at most one low", grnt_s);
    end
  endtask

  task automatic do_reset();
    req_v  = 4'b1111;
    reset  = 1'b1;
    tick();
    reset  = 1'b0;
  endtask

  task automatic test_reset();
    m_rdy_ = 1'b0;
    req_v  = 4'b1111;
    reset  = 1'b1;
    tick();
    tests_run++;
    if (obs_s !== {4'b1111, 2'd0, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_state: got %b required %b", obs_s, {4'b1111, 2'd0, 1'b0, 1'b0});
    end
    reset = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    req_v = 4'b1011;
    tick();
    tests_run++;
    if (obs_s !== {4'b1011, 2'd2, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL single_grant_m2: got %b required %b", obs_s, {4'b1011, 2'd2, 1'b1, 1'b0});
    end
    req_v = 4'b1111;
    tick();
    tests_run++;
    if (obs_s !== {4'b1111, 2'd2, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL single_release_m2: got %b required %b", obs_s, {4'b1111, 2'd2, 1'b0, 1'b0});
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_idx;
    do_reset();
    req_v = 4'b0000;
    tick();
    tests_run++;
    if (obs_s !== {4'b1110, 2'd0, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL rr_first_m0: got %b required %b", obs_s, {4'b1110, 2'd0, 1'b1, 1'b0});
    end
    // Current owner (k-1) drops its request for exactly one cycle.
    for (int k = 1; k <= 4; k++) begin
      req_v   = 4'b0001 << (k - 1);
      exp_idx = 2'(k);
      tick();
      tests_run++;
      if (obs_s !== {~(4'b0001 << exp_idx), exp_idx, 1'b1, 1'b0}) begin
        tests_failed++;
        $display("FAIL rr_handover_%0d: got %b required %b", k, obs_s,
                 {~(4'b0001 << exp_idx), exp_idx, 1'b1, 1'b0});
      end
    end
    req_v = 4'b1111;
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    req_v = 4'b1101;
    tick();
    req_v = 4'b0100;            // m3 and m0 join while m1 owns
    tick();
    tests_run++;
    if (obs_s !== {4'b1101, 2'd1, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL b2b_m1_holds: got %b required %b", obs_s, {4'b1101, 2'd1, 1'b1, 1'b0});
    end
    req_v = 4'b0110;            // m1 releases
    tick();
    tests_run++;
    if (obs_s !== {4'b0111, 2'd3, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL b2b_m3_next: got %b required %b", obs_s, {4'b0111, 2'd3, 1'b1, 1'b0});
    end
    req_v = 4'b1110;            // m3 releases
    tick();
    tests_run++;
    if (obs_s !== {4'b1110, 2'd0, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL b2b_m0_next: got %b required %b", obs_s, {4'b1110, 2'd0, 1'b1, 1'b0});
    end
    req_v = 4'b1111;
    tick();
  endtask

  task automatic test_reset_mid_owner();
    do_reset();
    req_v = 4'b1101;
    tick();
    tests_run++;
    if (obs_s !== {4'b1101, 2'd1, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL midrst_owned: got %b required %b", obs_s, {4'b1101, 2'd1, 1'b1, 1'b0});
    end
    reset = 1'b1;
    tick();
    tests_run++;
    if (obs_s !== {4'b1111, 2'd0, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL midrst_drop: got %b required %b", obs_s, {4'b1111, 2'd0, 1'b0, 1'b0});
    end
    reset = 1'b0;
    tick();
    tests_run++;
    if (obs_s !== {4'b1101, 2'd1, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL midrst_regrant: got %b required %b", obs_s, {4'b1101, 2'd1, 1'b1, 1'b0});
    end
    req_v = 4'b1111;
    tick();
  endtask

`ifdef BUS_ARB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    m_rdy_ = 1'b1;
    req_v  = 4'b1100;
    tick();
    repeat (4) tick();          // counter climbs 1..4 while m0 owns
    tests_run++;
    if (obs_s !== {4'b1110, 2'd0, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL to_before: got %b required %b", obs_s, {4'b1110, 2'd0, 1'b1, 1'b0});
    end
    tick();
    tests_run++;
    if (obs_s !== {4'b1101, 2'd1, 1'b1, 1'b1}) begin
      tests_failed++;
      $display("FAIL to_force: got %b required %b", obs_s, {4'b1101, 2'd1, 1'b1, 1'b1});
    end
    req_v = 4'b1110;            // m1 releases, m0 still low but blocked
    tick();
    tests_run++;
    if (obs_s !== {4'b1111, 2'd1, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL to_blocked: got %b required %b", obs_s, {4'b1111, 2'd1, 1'b0, 1'b0});
    end
    req_v = 4'b1111;
    tick();
    req_v = 4'b1110;
    tick();
    tests_run++;
    if (obs_s !== {4'b1110, 2'd0, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL to_unblock: got %b required %b", obs_s, {4'b1110, 2'd0, 1'b1, 1'b0});
    end
    req_v  = 4'b1111;
    m_rdy_ = 1'b0;
    tick();
  endtask
`else
  task automatic test_no_timeout();
    int bad_cycles;
    bad_cycles = 0;
    do_reset();
    m_rdy_ = 1'b1;
    req_v  = 4'b1100;
    tick();
    tests_run++;
    if (obs_s !== {4'b1110, 2'd0, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL hold_grant: got %b required %b", obs_s, {4'b1110, 2'd0, 1'b1, 1'b0});
    end
    for (int c = 0; c < 1000; c++) begin
      tick();
      if (obs_s !== {4'b1110, 2'd0, 1'b1, 1'b0}) bad_cycles++;
    end
    tests_run++;
    if (bad_cycles !== 0) begin
      tests_failed++;
      $display("FAIL hold_1000: %0d cycles lost grant or pulsed timeout, required 0", bad_cycles);
    end
    req_v  = 4'b1111;
    m_rdy_ = 1'b0;
    tick();
  endtask
`endif

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    req_v        = 4'b1111;
    m_rdy_       = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_back_to_back();
    test_reset_mid_owner();
`ifdef BUS_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_rr.md
Name: bus_arbiter_rr

Overview:
- Round-robin arbiter granting ownership of the shared system bus to one of four bus masters.
- Sits in front of the bus master mux / address decoder / slave mux.
- The granted master drives the bus until it releases its request. Grant changes are registered, so ownership never changes mid-cycle.
- Watchdog release of a hung owner is optional.

Parameters:
TIMEOUT_CYCLES, 255, consecutive not-ready owned cycles before forced release (used only with BUS_ARB_TIMEOUT_EN)
TO_CNT_W, 8, watchdog counter width; must hold TIMEOUT_CYCLES

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
m0_req_  input  1  master 0 bus request, active low
m1_req_  input  1  master 1 bus request, active low
m2_req_  input  1  master 2 bus request, active low
m3_req_  input  1  master 3 bus request, active low
m_rdy_  input  1  ready from slave mux, active low (watchdog only)
m0_grnt_  output  1  master 0 grant, active low, registered
m1_grnt_  output  1  master 1 grant, active low, registered
m2_grnt_  output  1  master 2 grant, active low, registered
m3_grnt_  output  1  master 3 grant, active low, registered
owner  output  2  index of current/last owner, registered
bus_busy  output  1  high while any grant is asserted
timeout  output  1  one-cycle high pulse on forced release

Behaviour:
- Interface decision: one clock, clk; reset is synchronous and active-high.
- Reset: all mN_grnt_=1, owner=0, bus_busy=0, timeout=0, state=IDLE, rr pointer last=3 (m0 has first priority).
- Reset applied mid-ownership drops the grant at that edge; there is no drain.
- State IDLE:
  - Each edge, sample the req_ lines.
  - If any are low, pick the first requester scanning (last+1)%4, (last+2)%4, (last+3)%4, last.
  - At that edge: its grnt_ goes low, owner=winner, bus_busy=1, state=OWNED.
  - Grant latency is 1 cycle from the first sampled request.
- State OWNED:
  - Grant is held while owner's req_ stays low; there is no preemption.
  - When owner's req_ is sampled high, at that edge: last=owner, and arbitration runs over the remaining low requests.
  - If there is a winner, hand over in the same edge: old grnt_ goes high and new grnt_ goes low. There is no idle cycle, and at no time are two grants low.
  - If there is no winner: all grnt_=1, bus_busy=0, state=IDLE, owner keeps its last value.
- Requests are level-sensitive and not latched. A req_ withdrawn before grant is forgotten.
- Simultaneous requests resolve by round-robin order only. Each master is granted at most once per 4 handovers when all four request continuously.
- At most one grnt_ low at any time (assertion in bench).
- owner and bus_busy change only on the edges where a grant changes.

Optional Feature:
- Macro: BUS_ARB_TIMEOUT_EN.
- With the macro defined:
  - TO_CNT_W counter, cleared on every grant change and whenever m_rdy_ is sampled low.
  - Increments each OWNED cycle with m_rdy_=1.
  - On reaching TIMEOUT_CYCLES, at the next edge the owner is force-released exactly like a voluntary release (same-edge handover allowed), and timeout pulses high for 1 cycle.
  - The released master is then blocked: it is excluded from arbitration until its req_ is sampled high at least once.
  - Counter saturates and never wraps.
- Without the macro: no counter and no block flag; m_rdy_ is unused; timeout is tied to 0.

Test Plan:
- Reset, then m2_req_=0 alone -> m2_grnt_=0 one cycle later, owner=2, bus_busy=1. m2_req_=1 -> next edge all grnt_=1, bus_busy=0, owner stays 2.
- Reset, then all four req_ low together and held -> grant order m0,m1,m2,m3,m0. Each owner drops req_ for 1 cycle to release. Handover has zero idle cycles and never two grants low.
- m1 owns, m3 and m0 requesting, m1 releases (last=1) -> m3 granted at the same edge; after m3 releases -> m0 granted.
- m1 owns, reset asserted for 1 cycle while m1_req_ stays low -> all grnt_=1 and owner=0 at that edge. After reset deasserts, m1_grnt_=0 one cycle later.
- With BUS_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=4: m0 owns with m_rdy_=1 held -> forced release after 4 cycles, timeout=1 for one cycle, m1 (requesting) granted at the same edge. m0_req_ held low stays ungranted until it goes high for one cycle and then requests again.
- Without BUS_ARB_TIMEOUT_EN: same stimulus for 1000 cycles -> m0 keeps grant, timeout stays 0.
